fetcher: RTL and testbench



---
 rtl/fetcher.sv | 138 +++++++++++++
 tb/tb_fetcher.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetcher.sv
// Per-core instruction fetcher: responder side of the FETCH/DECODE handshake.
// Optional direct-mapped instruction cache enabled by FETCHER_ICACHE_EN.
module fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int CACHE_LINES           = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             cache_flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        FETCHING = 3'b001,
        FETCHED  = 3'b010
    } state_t;

    state_t                             state_q, state_d;
    logic                               valid_q, valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0]   addr_q, addr_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0]   instr_q, instr_d;
    logic                               hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0]   hit_data;

`ifdef FETCHER_ICACHE_EN
    localparam int IDX_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

    logic [PROGRAM_MEM_DATA_BITS-1:0] line_data [CACHE_LINES];
    logic [TAG_BITS-1:0]              line_tag  [CACHE_LINES];
    logic [CACHE_LINES-1:0]           line_valid;
    logic [IDX_BITS-1:0]              rd_idx;
    logic [IDX_BITS-1:0]              wr_idx;
    logic                             fill;

    assign rd_idx   = current_pc[IDX_BITS-1:0];
    assign wr_idx   = addr_q[IDX_BITS-1:0];
    assign hit_data = line_data[rd_idx];
    assign hit      = line_valid[rd_idx] &&
                      (line_tag[rd_idx] ==
                       current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS]);
    // Fill uses the in-flight address, not the live PC.
    assign fill     = (state_q == FETCHING) && mem_read_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_valid <= '0;
        end else if (cache_flush) begin
            line_valid <= '0;
        end else if (fill) begin
            line_valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            line_data[wr_idx] <= mem_read_data;
            line_tag[wr_idx]  <= addr_q[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
        end
    end
`else
    logic unused_flush;

    assign unused_flush = cache_flush;
    assign hit          = 1'b0;
    assign hit_data     = '0;
`endif

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                if (core_state == CORE_FETCH) begin
                    if (hit) begin
                        instr_d = hit_data;
                        state_d = FETCHED;
                    end else begin
                        valid_d = 1'b1;
                        addr_d  = current_pc;
                        state_d = FETCHING;
                    end
                end
            end
            FETCHING: begin
                valid_d = 1'b1;
                if (mem_read_ready) begin
                    instr_d = mem_read_data;
                    valid_d = 1'b0;
                    state_d = FETCHED;
                end
            end
            FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
        end
    end

    assign fetcher_state    = state_q;
    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;
    assign instruction      = instr_q;

endmodule

// File: tb/tb_fetcher.sv
// Scoreboard bench for fetcher: expected instructions are queued per request
// and checked when FETCHED appears. Cache scenarios need FETCHER_ICACHE_EN.
module tb_fetcher;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  core_state = 3'b000;
    logic [7:0]  current_pc = 8'h00;
    logic        cache_flush = 1'b0;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready = 1'b0;
    logic [15:0] mem_read_data = 16'h0000;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;

    localparam logic [2:0] S_IDLE     = 3'b000;
    localparam logic [2:0] S_FETCHING = 3'b001;
    localparam logic [2:0] S_FETCHED  = 3'b010;
    localparam logic [2:0] C_FETCH    = 3'b001;
    localparam logic [2:0] C_DECODE   = 3'b010;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q[$];

    fetcher dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .cache_flush      (cache_flush),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input logic [2:0] exp);
        tests++;
        if (fetcher_state !== exp) begin
            fails++;
            $display("FAIL %s: state got %b want %b", name, fetcher_state, exp);
        end
    endtask

    task automatic check_req(input string name, input logic v,
                             input logic [7:0] a);
        tests++;
        if (mem_read_valid !== v || (v && mem_read_address !== a)) begin
            fails++;
            $display("FAIL %s: valid/addr got %b/%h want %b/%h",
                     name, mem_read_valid, mem_read_address, v, a);
        end
    endtask

    task automatic check_instr(input string name, input logic [15:0] exp);
        tests++;
        if (instruction !== exp) begin
            fails++;
            $display("FAIL %s: instruction got %h want %h",
                     name, instruction, exp);
        end
    endtask

    task automatic score(input string name);
        logic [15:0] exp;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: scoreboard empty, got %h want none",
                     name, instruction);
        end else begin
            exp = exp_q.pop_front();
            if (fetcher_state !== S_FETCHED || instruction !== exp) begin
                fails++;
                $display("FAIL %s: state/instr got %b/%h want %b/%h",
                         name, fetcher_state, instruction, S_FETCHED, exp);
            end
        end
    endtask

    // Full memory-path fetch; the response comes after `waits` FETCHING cycles.
    task automatic fetch_word(input string name, input logic [7:0] pc,
                              input logic [15:0] data, input int waits);
        exp_q.push_back(data);
        core_state = C_FETCH;
        current_pc = pc;
        tick();
        check_state({name, "_issue"}, S_FETCHING);
        check_req({name, "_req0"}, 1'b1, pc);
        for (int i = 1; i < waits; i++) begin
            tick();
            check_req({name, "_hold"}, 1'b1, pc);
        end
        mem_read_ready = 1'b1;
        mem_read_data  = data;
        tick();
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        check_req({name, "_done"}, 1'b0, pc);
        score(name);
    endtask

    task automatic decode(input string name);
        core_state = C_DECODE;
        tick();
        core_state = 3'b000;
        check_state({name, "_idle"}, S_IDLE);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        core_state = 3'b000;
        mem_read_ready = 1'b0;
        cache_flush = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        check_state("reset_state", S_IDLE);
        check_req("reset_req", 1'b0, 8'h00);
        tests++;
        if (mem_read_address !== 8'h00) begin
            fails++;
            $display("FAIL reset_addr: got %h want 00", mem_read_address);
        end
        check_instr("reset_instr", 16'h0000);
    endtask

    task automatic test_basic_fetch();
        fetch_word("basic", 8'h05, 16'h3A17, 3);
    endtask

    task automatic test_decode_handshake();
        for (int i = 0; i < 4; i++) begin
            tick();
            check_state("hold_fetched", S_FETCHED);
        end
        decode("handshake");
        check_instr("instr_after_decode", 16'h3A17);
    endtask

    task automatic test_spurious_ready();
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hFFFF;
        tick();
        mem_read_ready = 1'b0;
        check_state("spurious_state", S_IDLE);
        check_req("spurious_req", 1'b0, 8'h00);
        check_instr("spurious_instr", 16'h3A17);
    endtask

    task automatic test_async_reset();
        core_state = C_FETCH;
        current_pc = 8'h11;
        tick();
        check_state("ar_issue", S_FETCHING);
        #2;
        reset_n = 1'b0;
        core_state = 3'b000;
        #1;
        check_req("ar_drop", 1'b0, 8'h00);
        check_state("ar_state", S_IDLE);
        reset_n = 1'b1;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hDEAD;
        tick();
        mem_read_ready = 1'b0;
        check_state("ar_late_ready", S_IDLE);
        check_instr("ar_late_instr", 16'h0000);
    endtask

    task automatic test_pc_stability();
        exp_q.push_back(16'h5A5A);
        core_state = C_FETCH;
        current_pc = 8'h05;
        tick();
        current_pc = 8'h20;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_req("pc_stable", 1'b1, 8'h05);
        end
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h5A5A;
        tick();
        mem_read_ready = 1'b0;
        score("pc_stable_data");
        decode("pc_stable");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] pc;
            logic [15:0] d;
            pc = 8'(8'h40 + 8'(i * 7));
            d  = 16'($urandom_range(16'hFFFF, 0));
            fetch_word("b2b", pc, d, 1 + (i % 3));
            decode("b2b");
        end
    endtask

`ifdef FETCHER_ICACHE_EN
    task automatic hit_word(input string name, input logic [7:0] pc,
                            input logic [15:0] data);
        exp_q.push_back(data);
        core_state = C_FETCH;
        current_pc = pc;
        tick();
        check_req({name, "_novalid"}, 1'b0, pc);
        score(name);
        decode(name);
    endtask

    task automatic test_icache();
        do_reset();
        fetch_word("c_miss05", 8'h05, 16'h1234, 2);
        decode("c_miss05");
        hit_word("c_hit05", 8'h05, 16'h1234);
        fetch_word("c_miss09", 8'h09, 16'hBEEF, 1);
        decode("c_miss09");
        hit_word("c_hit09", 8'h09, 16'hBEEF);
        cache_flush = 1'b1;
        tick();
        cache_flush = 1'b0;
        fetch_word("c_flush09", 8'h09, 16'hC0DE, 1);
        decode("c_flush09");
    endtask
`endif

    initial begin
        test_reset();
        test_basic_fetch();
        test_decode_handshake();
        test_spurious_ready();
        test_async_reset();
        test_pc_stability();
        test_back_to_back();
`ifdef FETCHER_ICACHE_EN
        test_icache();
`endif
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
